booth_mul_seq: RTL

//   Sequential signed radix-4 Booth multiplier feeding the FFT butterfly datapath.
//   - Accepts one multiplicand/multiplier pair over a valid/ready handshake.
//   - Recodes the multiplier into 3-bit Booth windows, MSB window first.
//   - Accumulates one partial product per clock into a 2*W-bit register.
//   - Holds the finished product on a valid/ready output port until it is consumed.

---
 rtl/booth_mul_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential signed radix-4 Booth multiplier with valid/ready ports
module booth_mul_seq #(
    parameter int W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    localparam int CW = $clog2(W/2) > 0 ? $clog2(W/2) : 1;
    localparam int IW = $clog2(W+1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_START = CW'(W/2 - 1);

    logic [1:0]      state;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    a_reg;
    logic [W:0]      b_ext;
    logic [CW-1:0]   cnt;

    logic [IW-1:0]   win_base;
    logic [2:0]      win;
    logic [2*W-1:0]  a_pos;
    logic [2*W-1:0]  a_neg;
    logic [2*W-1:0]  pp;
    logic [2*W-1:0]  acc_next;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign product   = acc;

    // Select the current 3-bit Booth window, most significant window first
    always_comb begin
        win_base = IW'({cnt, 1'b0});
        win      = b_ext[win_base +: 3];
    end

    // Recode the window into a sign-extended partial product and form the next accumulator value
    always_comb begin
        a_pos = {{W{a_reg[W-1]}}, a_reg};
        a_neg = ~a_pos + ONE;
        pp    = '0;
        case (win)
            3'b001, 3'b010: pp = a_pos;
            3'b011:         pp = a_pos << 1;
            3'b100:         pp = a_neg << 1;
            3'b101, 3'b110: pp = a_neg;
            default:        pp = '0;
        endcase
        acc_next = (acc << 2) + pp;
    end

    // Control FSM and datapath registers: accept, one Booth step per clock, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            a_reg <= '0;
            b_ext <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_ext <= {b, 1'b0};
                        acc   <= '0;
                        cnt   <= CNT_START;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
